// File: rtl/mem_access_gate.sv
// rtl/mem_access_gate.sv - registered PMP check gate between core memory port and system bus
module mem_access_gate #(
    parameter bit          pmp_enable     = 1'b1,
    parameter int unsigned timeout_cycles = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_instr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [1:0]  req_priv,
    output logic        chk_valid,
    output logic        chk_instr,
    output logic [31:0] chk_addr,
    output logic [3:0]  chk_wstrb,
    output logic [1:0]  chk_priv,
    input  logic        chk_exception,
    input  logic [31:0] chk_etval,
    input  logic [3:0]  chk_ecause,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exception,
    output logic [31:0] rsp_etval,
    output logic [3:0]  rsp_ecause
);

    typedef enum logic [1:0] {IDLE, CHECK, BUS, RESP} state_t;

    localparam bit          TIMEOUT_EN   = (timeout_cycles != 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(timeout_cycles - 1);

    state_t      state, state_n;

    logic        instr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  priv_q;
    logic [15:0] cnt_q;
    logic [31:0] rdata_q;
    logic        exc_q;
    logic [31:0] etval_q;
    logic [3:0]  ecause_q;

    logic        deny;
    logic        timeout_hit;
    logic [3:0]  timeout_cause;

    assign deny          = pmp_enable && chk_exception;
    assign timeout_hit   = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);
    assign timeout_cause = instr_q ? 4'd1 : ((wstrb_q != 4'h0) ? 4'd7 : 4'd5);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Completion is tested before the watchdog so a ready on the expiry cycle wins.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = CHECK;
            CHECK:   state_n = deny ? RESP : BUS;
            BUS:     if (mem_ready || timeout_hit) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q  <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'h0;
            priv_q   <= 2'b00;
            cnt_q    <= 16'h0;
            rdata_q  <= 32'h0;
            exc_q    <= 1'b0;
            etval_q  <= 32'h0;
            ecause_q <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        instr_q  <= req_instr;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        wstrb_q  <= req_wstrb;
                        priv_q   <= req_priv;
                        rdata_q  <= 32'h0;
                        exc_q    <= 1'b0;
                        etval_q  <= 32'h0;
                        ecause_q <= 4'h0;
                    end
                end
                CHECK: begin
                    cnt_q <= 16'h0;
                    if (deny) begin
                        exc_q    <= 1'b1;
                        etval_q  <= chk_etval;
                        ecause_q <= chk_ecause;
                    end
                end
                BUS: begin
                    if (mem_ready) begin
                        rdata_q <= (wstrb_q == 4'h0) ? mem_rdata : 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 16'h1;
                        if (timeout_hit) begin
                            exc_q    <= 1'b1;
                            etval_q  <= addr_q;
                            ecause_q <= timeout_cause;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready     = 1'b0;
        chk_valid     = 1'b0;
        chk_instr     = 1'b0;
        chk_addr      = 32'h0;
        chk_wstrb     = 4'h0;
        chk_priv      = 2'b00;
        mem_valid     = 1'b0;
        mem_instr     = 1'b0;
        mem_addr      = 32'h0;
        mem_wdata     = 32'h0;
        mem_wstrb     = 4'h0;
        rsp_valid     = 1'b0;
        rsp_rdata     = 32'h0;
        rsp_exception = 1'b0;
        rsp_etval     = 32'h0;
        rsp_ecause    = 4'h0;
        case (state)
            IDLE: req_ready = 1'b1;
            CHECK: begin
                chk_valid = 1'b1;
                chk_instr = instr_q;
                chk_addr  = addr_q;
                chk_wstrb = wstrb_q;
                chk_priv  = priv_q;
            end
            BUS: begin
                mem_valid = 1'b1;
                mem_instr = instr_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wstrb = wstrb_q;
            end
            RESP: begin
                rsp_valid     = 1'b1;
                rsp_rdata     = rdata_q;
                rsp_exception = exc_q;
                rsp_etval     = etval_q;
                rsp_ecause    = ecause_q;
            end
            default: ;
        endcase
    end

endmodule
